// File: rtl/adding_machine_sequencer.sv
// adding_machine_sequencer: sequences the index->ROM->pipe->ALU->acc datapath
// over a latched word range; reports busy/done.
//
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   start            : begin a run (sampled only when idle)
//   base_index       : first word index of the range
//   length           : number of words to sum (0 legal)
//   stall            : freeze datapath and sequencer this cycle
//   index            : word index to ROM
//   pipe_en          : pipeline register capture enable
//   acc_en           : accumulator add enable
//   acc_clear        : one-cycle accumulator clear
//   busy, done       : run in progress / one-cycle completion pulse
//
// Optional: define ACC_OVERFLOW_EN to add carry_in (ALU carry-out) and a
// sticky overflow flag, cleared by acc_clear or reset.

module adding_machine_sequencer #(
  parameter int ADDR_W = 30,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_index,
  input  logic [LEN_W-1:0]  length,
  input  logic              stall,
`ifdef ACC_OVERFLOW_EN
  input  logic              carry_in,
  output logic              overflow,
`endif
  output logic [ADDR_W-1:0] index,
  output logic              pipe_en,
  output logic              acc_en,
  output logic              acc_clear,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [ADDR_W-1:0]  index_q;
  logic [ADDR_W-1:0]  index_d;
  logic [LEN_W-1:0]   rem_q;
  logic [LEN_W-1:0]   rem_d;
  // valid_q: pipeline register holds a word not yet added
  logic               valid_q;
  logic               valid_d;
  // clr_q: fires once in the cycle after an accepted start,
  // independent of stall, so the accumulator is always zeroed
  logic               clr_q;
  logic               clr_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      index_q <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
      clr_q   <= clr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    rem_d   = rem_q;
    valid_d = valid_q;
    clr_d   = 1'b0;
    pipe_en = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    // Add whenever the pipe register holds unsummed data
    acc_en  = valid_q & ~stall;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          index_d = base_index;
          rem_d   = length;
          clr_d   = 1'b1;
          if (length == '0) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_FETCH;
          end
        end
      end

      S_FETCH: begin
        busy = 1'b1;
        if (!stall) begin
          pipe_en = 1'b1;
          index_d = index_q + ADDR_W'(1);
          rem_d   = rem_q - LEN_W'(1);
          valid_d = 1'b1;
          if (rem_q == LEN_W'(1)) begin
            state_d = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        busy = 1'b1;
        if (!stall) begin
          valid_d = 1'b0;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign index     = index_q;
  assign acc_clear = clr_q;

`ifdef ACC_OVERFLOW_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (clr_q) begin
      ovf_q <= 1'b0;
    end else if (acc_en && carry_in) begin
      ovf_q <= 1'b1;
    end
  end

  assign overflow = ovf_q;
`endif

  a_clr_excl: assert property (
    @(posedge clk) disable iff (reset)
    !(acc_clear && acc_en)
  );

  a_done_idle: assert property (
    @(posedge clk) disable iff (reset)
    done |-> !(busy || pipe_en || acc_en)
  );

endmodule
